dot_matrix_scanner: RTL
=======================

// Module: dot_matrix_scanner
// PURPOSE
//  Row-scan driver for the 16x16 LED dot matrix of the traffic-light display.
//  Sits directly upstream of the row-pattern ROM: it drives the 4-bit row
//  index to that ROM, takes back the 16-bit column pattern and drives the
//  physical row/column lines.
//  Includes anti-ghosting blanking between rows, optional blinking and a
//  frame-done pulse for the light-sequencing controller.
// PARAMETERS
//  CLK_DIV       1000  clk cycles per row slot (blank + show); must be > BLANK_CYCLES
//  BLANK_CYCLES  20    cycles at start of each slot with row/col lines dark; >= 1
//  BLINK_FRAMES  25    frames per blink phase (visible / dark) when blink=1; >= 1
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   synchronous, active-high reset
//  en          in   1   1 = scan; 0 = display dark, scanner idle
//  blink       in   1   1 = alternate visible/dark every BLINK_FRAMES frames
//  col_in      in   16  column pattern from ROM for current row_bin (combinational)
//  row_bin     out  4   row index to pattern ROM
//  row_drv     out  16  one-hot row enable, bit n = row n, active-high
//  col_drv     out  16  column drive, bit 15 = leftmost, active-high
//  frame_done  out  1   one-cycle pulse per completed 16-row frame
// BEHAVIOUR
//  - Reset, sync on clk: row_bin=0, row_drv=0, col_drv=0, frame_done=0,
//    slot counter=0, frame counter=0, blink phase=visible, state=IDLE.
//  - All outputs are registered.
//  - FSM states:
//    IDLE : outputs dark, row_bin=0. en=1 -> BLANK next cycle.
//    BLANK: row_drv=0, col_drv=0, BLANK_CYCLES cycles.
//           The last BLANK cycle captures col_in (ANDed with the visible mask) into col_drv.
//           row_drv <= 1<<row_bin on the same edge -> SHOW.
//    SHOW : row_drv/col_drv held, CLK_DIV-BLANK_CYCLES cycles.
//           On the last cycle, row_bin <= row_bin+1 (wraps 15->0) -> BLANK.
//  - Slot counter 0..CLK_DIV-1 spans BLANK+SHOW. row_bin changes only at slot
//    boundaries, so col_in has BLANK_CYCLES cycles to settle before capture.
//  - Row slot n starts (BLANK, first cycle) exactly n*CLK_DIV cycles after the
//    first BLANK cycle of the frame. Frame period = 16*CLK_DIV cycles.
//  - frame_done: high for exactly the first BLANK cycle of row 0 following a
//    completed row-15 SHOW. Not asserted on the first frame after IDLE.
//  - Blink:
//    blink=0: phase forced visible.
//    blink=1: frame counter 0..BLINK_FRAMES-1 increments on each frame_done;
//             at wrap the phase toggles.
//    Dark phase: col_drv=0, but row_bin/row_drv keep scanning and frame_done
//             keeps pulsing.
//    blink 1->0 mid-frame: visible from the next capture; frame counter cleared.
//  - en 1->0 in any state: next cycle IDLE, all outputs 0, row_bin=0,
//    counters and blink phase reset. en 0->1 restarts at row 0 BLANK;
//    the partial frame produces no frame_done.
//  - rst wins over en. rst mid-frame behaves as reset; scan restarts at row 0
//    the cycle after rst falls, if en=1.
//  - row_drv is never non-zero while col_drv changes, and at most one row_drv
//    bit is set.
// STRUCTURE
//  - Shared include dm_defs.vh:
//    DM_ROWS=16, DM_COLS=16, DM_ROW_W=4, FSM state encodings
//    (ST_IDLE, ST_BLANK, ST_SHOW).
//  - Sub-module scan_timer: slot counter with parameter CLK_DIV.
//    Outputs blank_end and slot_end strobes; clear on rst or !en.
//  - FSM, row counter, blink/frame logic in the top; the pattern ROM is
//    instantiated by the parent, not here.
// TESTING (bench: CLK_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, behavioural ROM model)
//  1. rst=1 for 3 cycles, en=1 -> all outputs 0; first cycle after release: state BLANK, row_bin=0.
//  2. en=1, slot 2 -> row_bin=2; slot cycles 0-1 dark; cycles 2-7 row_drv=16'h0004, col_drv=16'h1E00.
//  3. Free run -> frame_done pulses every 128 cycles, width 1; first pulse 128 cycles after first BLANK.
//  4. blink=1 from reset -> frames 0-1 col_drv follows ROM; frames 2-3 col_drv=0, row_drv still scans; frame 4 visible.
//  5. en=0 during row 7 SHOW -> next cycle row_drv=0, col_drv=0, row_bin=0.
//     en=1 -> row 0 restarts; no frame_done until 128 cycles later.
//  6. Every cycle: $onehot0(row_drv), and col_drv changes only while row_drv==0 (assertions).

Source files
------------

// File: rtl/dot_matrix_scanner_pkg.sv
// Shared widths, FSM state type and row-decode helper for the dot-matrix row scanner.
package dot_matrix_scanner_pkg;

    localparam int unsigned DM_ROWS  = 16;
    localparam int unsigned DM_COLS  = 16;
    localparam int unsigned DM_ROW_W = 4;

    typedef logic [DM_ROW_W-1:0] row_idx_t;
    typedef logic [DM_ROWS-1:0]  row_vec_t;
    typedef logic [DM_COLS-1:0]  col_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } dm_state_t;

    // One-hot row enable for a row index (bit n = row n).
    function automatic row_vec_t row_onehot(input row_idx_t idx);
        row_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dot_matrix_scanner_if.sv
// Scanner-side signal bundle: row index / column pattern to and from the
// pattern ROM, plus the physical row/column drive and the frame strobe.
interface dot_matrix_scanner_if;
    import dot_matrix_scanner_pkg::*;

    row_idx_t row_bin;
    col_vec_t col_in;
    row_vec_t row_drv;
    col_vec_t col_drv;
    logic     frame_done;

    modport master (
        output row_bin,
        output row_drv,
        output col_drv,
        output frame_done,
        input  col_in
    );

    modport slave (
        input  row_bin,
        input  row_drv,
        input  col_drv,
        input  frame_done,
        output col_in
    );

endinterface

// File: rtl/dot_matrix_scanner_scan_timer.sv
// Row-slot timer: counts 0..CLK_DIV-1 across one blank+show slot and strobes
// the last blank cycle and the last cycle of the slot.
module scan_timer #(
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned BLANK_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic run,
    output logic blank_end,
    output logic slot_end
);

    localparam int unsigned      CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] slot_cnt;

    // Slot counter: held at 0 while idle/disabled so the first BLANK cycle is count 0.
    always_ff @(posedge clk) begin
        if (rst || !en || !run) begin
            slot_cnt <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    assign blank_end = run && (slot_cnt == BLANK_LAST);
    assign slot_end  = run && (slot_cnt == SLOT_LAST);

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for the 16x16 LED matrix: walks row_bin through the pattern
// ROM, blanks between rows against ghosting, optionally blinks whole frames
// and pulses frame_done after each completed 16-row frame.
module dot_matrix_scanner
    import dot_matrix_scanner_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned BLANK_CYCLES = 20,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 blink,
    dot_matrix_scanner_if.master bus
);

    localparam int unsigned       FCNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam row_idx_t          ROW_LAST  = row_idx_t'(DM_ROWS - 1);

    dm_state_t state;
    dm_state_t state_nxt;

    logic blank_end;
    logic slot_end;
    logic running;

    row_idx_t row_bin_q;
    row_idx_t row_bin_d;
    row_vec_t row_drv_q;
    row_vec_t row_drv_d;
    col_vec_t col_drv_q;
    col_vec_t col_drv_d;
    logic     frame_done_q;
    logic     frame_done_d;

    logic              frame_end;
    logic [FCNT_W-1:0] frame_cnt;
    logic              phase_dark;
    logic              visible;

    assign running = (state != ST_IDLE);

    scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .run       (running),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    // Last SHOW cycle of row 15: the frame completes on this edge.
    assign frame_end = en && (state == ST_SHOW) && slot_end && (row_bin_q == ROW_LAST);

    // Mask is combinational on blink so dropping blink shows at the very next capture.
    assign visible = !blink || !phase_dark;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: disable returns to IDLE from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_BLANK;
            ST_BLANK: begin
                if (!en)            state_nxt = ST_IDLE;
                else if (blank_end) state_nxt = ST_SHOW;
            end
            ST_SHOW:  begin
                if (!en)           state_nxt = ST_IDLE;
                else if (slot_end) state_nxt = ST_BLANK;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered row/column drive.
    always_comb begin
        row_bin_d    = row_bin_q;
        row_drv_d    = row_drv_q;
        col_drv_d    = col_drv_q;
        frame_done_d = 1'b0;
        if (!en) begin
            row_bin_d = '0;
            row_drv_d = '0;
            col_drv_d = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    row_drv_d = '0;
                    col_drv_d = '0;
                    if (blank_end) begin
                        row_drv_d = row_onehot(row_bin_q);
                        col_drv_d = bus.col_in & {DM_COLS{visible}};
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        row_bin_d    = row_bin_q + row_idx_t'(1);
                        row_drv_d    = '0;
                        col_drv_d    = '0;
                        frame_done_d = frame_end;
                    end
                end
                default: begin
                    row_bin_d = '0;
                    row_drv_d = '0;
                    col_drv_d = '0;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_bin_q    <= '0;
            row_drv_q    <= '0;
            col_drv_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_bin_q    <= row_bin_d;
            row_drv_q    <= row_drv_d;
            col_drv_q    <= col_drv_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Blink phase: advanced at frame completion so the following row-0 capture
    // already sees the new phase, even with a single blank cycle.
    always_ff @(posedge clk) begin
        if (rst || !en || !blink) begin
            frame_cnt  <= '0;
            phase_dark <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FCNT_LAST) begin
                frame_cnt  <= '0;
                phase_dark <= !phase_dark;
            end else begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign bus.row_bin    = row_bin_q;
    assign bus.row_drv    = row_drv_q;
    assign bus.col_drv    = col_drv_q;
    assign bus.frame_done = frame_done_q;

endmodule
